ag_o_ex: RTL and testbench

//  Address generator for the extraction (read-out) port of the systolic-array output DPR (sys_out).

---
 rtl/ag_o_ex.sv | 112 +++++++++++
 tb/tb_ag_o_ex.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ag_o_ex.sv
// ag_o_ex: extraction-port address generator for the sys_out DPR.
// Sweeps GAMMA tiles of P rows (last tile partial) and flags done.
module ag_o_ex #(
    parameter int FEATURE_BITS = 4,
    parameter int M            = 9,
    parameter int GAMMA        = 3,
    parameter int P            = 4
) (
    input  logic                      sys_clk,
    input  logic                      reset_n,
    input  logic                      start,
    output logic [2*FEATURE_BITS-1:0] address_ex,
    output logic                      done
);

    localparam int FB        = FEATURE_BITS;
    localparam int LAST_ROWS = M - (GAMMA - 1) * P;

    localparam logic [FB-1:0] LIM_FULL = FB'(P - 1);
    localparam logic [FB-1:0] LIM_LAST = FB'(LAST_ROWS - 1);
    localparam logic [FB-1:0] T_LAST   = FB'(GAMMA - 1);

    if (GAMMA != (M + P - 1) / P) begin : g_bad_gamma
        $error("ag_o_ex: GAMMA must equal ceil(M/P)");
    end
    if (M < 1 || M > 2**FB - 1) begin : g_bad_m
        $error("ag_o_ex: M out of range");
    end
    if (P < 1 || P > 2**FB) begin : g_bad_p
        $error("ag_o_ex: P out of range");
    end
    if (GAMMA < 1 || GAMMA > 2**FB) begin : g_bad_g
        $error("ag_o_ex: GAMMA out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [FB-1:0] r_tile;
    logic [FB-1:0] r_row;
    logic [FB-1:0] w_tile_nxt;
    logic [FB-1:0] w_row_nxt;
    logic [FB-1:0] w_lim;
    logic          r_done;

    // Row limit depends on whether the current tile is the (possibly partial) last one
    always_comb begin
        w_lim = (r_tile == T_LAST) ? LIM_LAST : LIM_FULL;
    end

    // Next-state and counter update for the sweep
    always_comb begin
        w_state_nxt = r_state;
        w_tile_nxt  = r_tile;
        w_row_nxt   = r_row;
        unique case (r_state)
            S_IDLE: begin
                w_tile_nxt = '0;
                w_row_nxt  = '0;
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_row < w_lim) begin
                    w_row_nxt = r_row + 1'b1;
                end else if (r_tile < T_LAST) begin
                    w_tile_nxt = r_tile + 1'b1;
                    w_row_nxt  = '0;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    w_state_nxt = S_IDLE;
                    w_tile_nxt  = '0;
                    w_row_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tile_nxt  = '0;
                w_row_nxt   = '0;
            end
        endcase
    end

    // State, counters and done flag registers
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_tile  <= '0;
            r_row   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tile  <= w_tile_nxt;
            r_row   <= w_row_nxt;
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign address_ex = {r_tile, r_row};
    assign done       = r_done;

endmodule

// File: tb/tb_ag_o_ex.sv
// tb_ag_o_ex: directed table-driven bench for ag_o_ex,
// default build plus an M=8/P=4/GAMMA=2 build.
module tb_ag_o_ex;

    logic       clk;
    logic       rst_n;
    logic       start_a;
    logic       start_b;
    logic [7:0] addr_a;
    logic [7:0] addr_b;
    logic       done_a;
    logic       done_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       s;
        logic [7:0] a;
        logic       d;
    } vec_t;

    vec_t tbl[$];

    ag_o_ex #(
        .FEATURE_BITS(4), .M(9), .GAMMA(3), .P(4)
    ) u_a (
        .sys_clk   (clk),
        .reset_n   (rst_n),
        .start     (start_a),
        .address_ex(addr_a),
        .done      (done_a)
    );

    ag_o_ex #(
        .FEATURE_BITS(4), .M(8), .GAMMA(2), .P(4)
    ) u_b (
        .sys_clk   (clk),
        .reset_n   (rst_n),
        .start     (start_b),
        .address_ex(addr_b),
        .done      (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] a,
                       input logic d, input logic [7:0] ea,
                       input logic ed);
        checks++;
        if (a !== ea || d !== ed) begin
            errors++;
            $display("FAIL %s: addr=%02h done=%0b expected addr=%02h done=%0b",
                     nm, a, d, ea, ed);
        end
    endtask

    task automatic add(input logic s, input logic [7:0] a, input logic d);
        vec_t v;
        v.s = s;
        v.a = a;
        v.d = d;
        tbl.push_back(v);
    endtask

    task automatic add_sweep(input logic s_first, input logic s_rest);
        logic [7:0] seq [9];
        seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10,
                8'h11, 8'h12, 8'h13, 8'h20};
        for (int i = 0; i < 9; i++) begin
            add((i == 0) ? s_first : s_rest, seq[i], 1'b0);
        end
    endtask

    task automatic step_a(input logic s);
        @(negedge clk);
        start_a = s;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic s);
        @(negedge clk);
        start_b = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // idle hold after reset
        add(0, 8'h00, 0);
        add(0, 8'h00, 0);
        // held start: full sweep, done, held start keeps DONE
        add_sweep(1, 1);
        add(1, 8'h20, 1);
        add(1, 8'h20, 1);
        // drop start -> IDLE, then identical sweep
        add(0, 8'h00, 0);
        add_sweep(1, 1);
        add(1, 8'h20, 1);
        add(0, 8'h00, 0);
        add(0, 8'h00, 0);
        // one-cycle start pulse still completes the sweep
        add_sweep(1, 0);
        add(0, 8'h20, 1);
        add(0, 8'h00, 0);
        add(0, 8'h00, 0);

        start_a = 1'b0;
        start_b = 1'b0;
        rst_n   = 1'b0;
        #12;
        chk("reset_a", addr_a, done_a, 8'h00, 1'b0);
        chk("reset_b", addr_b, done_b, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step_a(tbl[i].s);
            chk($sformatf("vec%0d", i), addr_a, done_a, tbl[i].a, tbl[i].d);
        end

        // async reset mid-sweep at address 0x12
        for (int i = 0; i < 7; i++) begin
            step_a(1'b1);
        end
        chk("pre_reset_12", addr_a, done_a, 8'h12, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", addr_a, done_a, 8'h00, 1'b0);
        start_a = 1'b0;
        @(negedge clk);
        chk("reset_held", addr_a, done_a, 8'h00, 1'b0);
        rst_n = 1'b1;
        step_a(1'b0);
        chk("post_reset_idle", addr_a, done_a, 8'h00, 1'b0);
        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < ((t == 2) ? 1 : 4); r++) begin
                step_a(1'b1);
                chk($sformatf("resweep_t%0d_r%0d", t, r), addr_a, done_a,
                    {4'(t), 4'(r)}, 1'b0);
            end
        end
        step_a(1'b1);
        chk("resweep_done", addr_a, done_a, 8'h20, 1'b1);
        step_a(1'b0);
        chk("resweep_idle", addr_a, done_a, 8'h00, 1'b0);

        // M=8, P=4, GAMMA=2: full last tile
        step_b(1'b0);
        chk("b_idle", addr_b, done_b, 8'h00, 1'b0);
        for (int t = 0; t < 2; t++) begin
            for (int r = 0; r < 4; r++) begin
                step_b(1'b1);
                chk($sformatf("b_t%0d_r%0d", t, r), addr_b, done_b,
                    {4'(t), 4'(r)}, 1'b0);
            end
        end
        step_b(1'b1);
        chk("b_done", addr_b, done_b, 8'h13, 1'b1);
        step_b(1'b0);
        chk("b_idle_after", addr_b, done_b, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
